// File: rtl/rv_lsu_pkg.sv
// Shared types for the load/store unit: FSM states, load size/sign codes,
// and the alignment rule shared by loads and stores.
package rv_lsu_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUS  = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // funct3[1:0] encodes access size for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return a[0];
      2'b10:   return a != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_rdata_ext.sv
// Combinational byte/halfword lane select with sign/zero extension of a
// 32-bit bus read word.
module lsu_rdata_ext
  import rv_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr, 3'b000} +: 8];
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  result = {24'd0, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  result = {16'd0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/rv_lsu.sv
// Load/store unit: single-outstanding req/ack data bus, misalignment and
// timeout traps, one-cycle registered passthrough for non-memory ops.
module rv_lsu
  import rv_lsu_pkg::*;
#(
  parameter logic [7:0] BUS_TIMEOUT = 8'd255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_flush,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_add,
  input  logic [31:0] i_result,
  input  logic        i_load,
  input  logic        i_store,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wsel,
  input  logic [2:0]  i_funct3,
  input  logic        i_reg_write,
  input  logic [4:0]  i_rd,
  input  logic        i_to_trap,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_wsel,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata,
  output logic        o_valid,
  output logic [31:0] o_result,
  output logic [4:0]  o_rd,
  output logic        o_reg_write,
  output logic        o_to_trap,
  output logic        o_misaligned,
  output logic        o_access_fault
);

  lsu_state_t  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        kill_q, kill_d;
  logic        load_q, load_d;
  logic        reg_write_q, reg_write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  add_lo_q, add_lo_d;
  logic [31:0] result_q, result_d;

  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  wsel_q, wsel_d;
  logic        valid_q, valid_d, rw_q, rw_d;
  logic        trap_q, trap_d, mis_q, mis_d, fault_q, fault_d;
  logic [31:0] res_q, res_d;
  logic [4:0]  rd_q, rd_d;

  logic [31:0] ext_data;
  logic        mem_op, killed;

  lsu_rdata_ext u_ext (
    .funct3 (funct3_q),
    .addr   (add_lo_q),
    .rdata  (i_bus_rdata),
    .result (ext_data)
  );

  assign mem_op = i_load | i_store;
  assign killed = kill_q | i_flush;

  always_comb begin
    state_d = state_q;    cnt_d = cnt_q;          kill_d = kill_q;
    load_d = load_q;      reg_write_d = reg_write_q;
    funct3_d = funct3_q;  add_lo_d = add_lo_q;    result_d = result_q;
    req_d = req_q;        we_d = we_q;            addr_d = addr_q;
    wdata_d = wdata_q;    wsel_d = wsel_q;
    res_d = res_q;        rd_d = rd_q;
    // Write-back strobes and trap flags are single-cycle pulses.
    valid_d = 1'b0; rw_d = 1'b0; trap_d = 1'b0; mis_d = 1'b0; fault_d = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (i_valid && !i_flush) begin
          load_d = i_load;   reg_write_d = i_reg_write;
          funct3_d = i_funct3; add_lo_d = i_add[1:0]; result_d = i_result;
          rd_d = i_rd;       res_d = i_result;
          if (i_to_trap) begin
            valid_d = 1'b1;
            trap_d  = 1'b1;
          end else if (mem_op && is_misaligned(i_funct3, i_add[1:0])) begin
            valid_d = 1'b1;
            mis_d   = 1'b1;
          end else if (mem_op) begin
            state_d = LSU_BUS;
            req_d   = 1'b1;
            we_d    = i_store;
            addr_d  = {i_add[31:2], 2'b00};
            wdata_d = i_wdata;
            wsel_d  = i_wsel;
            cnt_d   = 8'd0;
            kill_d  = 1'b0;
          end else begin
            valid_d = 1'b1;
            rw_d    = i_reg_write;
          end
        end
      end
      LSU_BUS: begin
        cnt_d = cnt_q + 8'd1;
        if (i_flush) kill_d = 1'b1;
        // A flushed request still runs to ack; only its write-back is dropped.
        if (i_bus_ack && req_q) begin
          req_d   = 1'b0;
          state_d = killed ? LSU_IDLE : LSU_RESP;
          valid_d = !killed;
          rw_d    = !killed && load_q && reg_write_q;
          if (load_q) res_d = ext_data;
          kill_d  = 1'b0;
        end else if (BUS_TIMEOUT != 8'd0 && cnt_d == BUS_TIMEOUT) begin
          req_d   = 1'b0;
          state_d = killed ? LSU_IDLE : LSU_RESP;
          valid_d = !killed;
          fault_d = !killed;
          kill_d  = 1'b0;
        end
      end
      LSU_RESP: begin
        state_d = LSU_IDLE;
        kill_d  = 1'b0;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= LSU_IDLE; cnt_q <= 8'd0;  kill_q <= 1'b0;
      load_q <= 1'b0;      reg_write_q <= 1'b0;
      funct3_q <= 3'd0;    add_lo_q <= 2'd0; result_q <= 32'd0;
      req_q <= 1'b0;       we_q <= 1'b0;     addr_q <= 32'd0;
      wdata_q <= 32'd0;    wsel_q <= 4'd0;
      valid_q <= 1'b0;     rw_q <= 1'b0;     trap_q <= 1'b0;
      mis_q <= 1'b0;       fault_q <= 1'b0;  res_q <= 32'd0; rd_q <= 5'd0;
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;   kill_q <= kill_d;
      load_q <= load_d;    reg_write_q <= reg_write_d;
      funct3_q <= funct3_d; add_lo_q <= add_lo_d; result_q <= result_d;
      req_q <= req_d;      we_q <= we_d;     addr_q <= addr_d;
      wdata_q <= wdata_d;  wsel_q <= wsel_d;
      valid_q <= valid_d;  rw_q <= rw_d;     trap_q <= trap_d;
      mis_q <= mis_d;      fault_q <= fault_d; res_q <= res_d; rd_q <= rd_d;
    end
  end

  assign o_ready        = (state_q == LSU_IDLE);
  assign o_bus_req      = req_q;
  assign o_bus_we       = we_q;
  assign o_bus_addr     = addr_q;
  assign o_bus_wdata    = wdata_q;
  assign o_bus_wsel     = wsel_q;
  assign o_valid        = valid_q;
  assign o_result       = res_q;
  assign o_rd           = rd_q;
  assign o_reg_write    = rw_q;
  assign o_to_trap      = trap_q;
  assign o_misaligned   = mis_q;
  assign o_access_fault = fault_q;

endmodule

// File: tb/tb_rv_lsu.sv
// Randomized scoreboard bench for rv_lsu: stimulus pushes expected write-back
// and bus transactions; a bus responder and a write-back monitor check them.
module tb_rv_lsu;

  localparam logic [7:0] TO = 8'd4;

  logic        i_clk = 1'b0, i_reset = 1'b1, i_flush = 1'b0, i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_add = '0, i_result = '0, i_wdata = '0;
  logic        i_load = 1'b0, i_store = 1'b0, i_reg_write = 1'b0, i_to_trap = 1'b0;
  logic [3:0]  i_wsel = '0;
  logic [2:0]  i_funct3 = '0;
  logic [4:0]  i_rd = '0;
  logic        o_bus_req, o_bus_we;
  logic [31:0] o_bus_addr, o_bus_wdata;
  logic [3:0]  o_bus_wsel;
  logic        i_bus_ack = 1'b0;
  logic [31:0] i_bus_rdata = '0;
  logic        o_valid, o_reg_write, o_to_trap, o_misaligned, o_access_fault;
  logic [31:0] o_result;
  logic [4:0]  o_rd;

  rv_lsu #(.BUS_TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid),
    .o_ready(o_ready), .i_add(i_add), .i_result(i_result), .i_load(i_load),
    .i_store(i_store), .i_wdata(i_wdata), .i_wsel(i_wsel), .i_funct3(i_funct3),
    .i_reg_write(i_reg_write), .i_rd(i_rd), .i_to_trap(i_to_trap),
    .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
    .o_bus_wdata(o_bus_wdata), .o_bus_wsel(o_bus_wsel), .i_bus_ack(i_bus_ack),
    .i_bus_rdata(i_bus_rdata), .o_valid(o_valid), .o_result(o_result),
    .o_rd(o_rd), .o_reg_write(o_reg_write), .o_to_trap(o_to_trap),
    .o_misaligned(o_misaligned), .o_access_fault(o_access_fault)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] add, result, wdata, rdata;
    logic [3:0]  wsel;
    logic [2:0]  f3;
    logic        load, store, rw, trap;
    logic [4:0]  rd;
    int          delay;
  } instr_t;

  typedef struct {
    logic [31:0] result;
    logic        chk_result, rw, trap, mis, fault;
    logic [4:0]  rd;
    int          lat, cap;
  } exp_t;

  typedef struct {
    logic [31:0] addr, wdata, rdata;
    logic        we;
    logic [3:0]  wsel;
    int          delay;
  } bus_t;

  exp_t exp_q[$];
  bus_t bus_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] d);
    int unsigned sh;
    logic [31:0] v;
    sh = (a % 4) * 8;
    case (f3)
      3'b000: begin v = (d >> sh) & 32'hFF; if (v >= 128) v = v - 256; end
      3'b100: v = (d >> sh) & 32'hFF;
      3'b001: begin v = (d >> ((a % 4) >= 2 ? 16 : 0)) & 32'hFFFF; if (v >= 32768) v = v - 65536; end
      3'b101: v = (d >> ((a % 4) >= 2 ? 16 : 0)) & 32'hFFFF;
      default: v = d;
    endcase
    return v;
  endfunction

  function automatic instr_t blank();
    instr_t t;
    t.add = '0; t.result = '0; t.wdata = '0; t.rdata = '0; t.wsel = '0; t.f3 = '0;
    t.load = 0; t.store = 0; t.rw = 0; t.trap = 0; t.rd = '0; t.delay = 0;
    return t;
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    int k;
    t = blank();
    k = $urandom_range(0, 3);
    t.load = (k == 1 || k == 2);
    t.store = (k == 3);
    case ($urandom_range(0, t.store ? 2 : 4))
      0: t.f3 = 3'b000;
      1: t.f3 = 3'b001;
      2: t.f3 = 3'b010;
      3: t.f3 = 3'b100;
      default: t.f3 = 3'b101;
    endcase
    t.trap = ($urandom_range(0, 15) == 0);
    t.add = $urandom; t.result = $urandom; t.wdata = $urandom; t.rdata = $urandom;
    t.wsel = 4'($urandom); t.rd = 5'($urandom); t.rw = 1'($urandom);
    t.delay = $urandom_range(0, 5);
    return t;
  endfunction

  // mode 0: normal; 1: flush together with valid; 2: flush the cycle after capture
  task automatic issue(input instr_t t, input int mode);
    exp_t e;
    bus_t b;
    int w;
    logic mem, mis;
    mem = t.load || t.store;
    mis = (t.f3[1:0] == 2'b01 && (t.add % 2) != 0) || (t.f3[1:0] == 2'b10 && (t.add % 4) != 0);
    @(negedge i_clk);
    i_add = t.add; i_result = t.result; i_wdata = t.wdata; i_wsel = t.wsel;
    i_funct3 = t.f3; i_load = t.load; i_store = t.store; i_reg_write = t.rw;
    i_rd = t.rd; i_to_trap = t.trap; i_valid = 1'b1;
    w = 0;
    while (!o_ready && w < 100) begin @(negedge i_clk); w++; end
    if (w >= 100) begin
      checks++; errors++;
      $display("FAIL ready_timeout actual=o_ready low expected=high within 100 cycles");
    end
    if (mode == 1) i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
    if (mode == 1) return;
    e.cap = cyc; e.rd = t.rd; e.result = '0; e.chk_result = 0;
    e.rw = 0; e.trap = 0; e.mis = 0; e.fault = 0; e.lat = 1;
    if (t.trap) e.trap = 1;
    else if (mem && mis) e.mis = 1;
    else if (mem) begin
      b.addr = t.add & 32'hFFFF_FFFC; b.we = t.store; b.wdata = t.wdata;
      b.wsel = t.wsel; b.rdata = t.rdata; b.delay = t.delay;
      bus_q.push_back(b);
      if (t.delay >= int'(TO)) begin e.fault = 1; e.lat = int'(TO) + 1; end
      else begin
        e.lat = t.delay + 2;
        if (t.load) begin e.result = ref_load(t.f3, t.add, t.rdata); e.chk_result = 1; e.rw = t.rw; end
      end
    end else begin
      e.result = t.result; e.chk_result = 1; e.rw = t.rw;
    end
    if (mode == 2 && mem && !mis && !t.trap) begin
      @(negedge i_clk); i_flush = 1'b1;
      @(posedge i_clk); #1 i_flush = 1'b0;
    end else exp_q.push_back(e);
  endtask

  // Write-back monitor
  exp_t me;
  always @(negedge i_clk) begin
    if (!i_reset && o_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid actual=o_valid=1 rd=%0d expected=no write-back", o_rd);
      end else begin
        me = exp_q.pop_front();
        chk("wb_rd", 32'(o_rd), 32'(me.rd));
        chk("wb_reg_write", 32'(o_reg_write), 32'(me.rw));
        chk("wb_to_trap", 32'(o_to_trap), 32'(me.trap));
        chk("wb_misaligned", 32'(o_misaligned), 32'(me.mis));
        chk("wb_access_fault", 32'(o_access_fault), 32'(me.fault));
        if (me.chk_result) chk("wb_result", o_result, me.result);
        chk("wb_latency", 32'(cyc - me.cap + 1), 32'(me.lat));
      end
    end
  end

  // Bus responder
  initial begin
    bus_t p;
    int n;
    forever begin
      @(negedge i_clk);
      if (!i_reset && o_bus_req) begin
        if (bus_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_req actual=o_bus_req=1 addr=%h expected=no request", o_bus_addr);
        end else begin
          p = bus_q.pop_front();
          n = 0;
          forever begin
            chk("bus_addr", o_bus_addr, p.addr);
            chk("bus_we", 32'(o_bus_we), 32'(p.we));
            if (p.we) begin
              chk("bus_wdata", o_bus_wdata, p.wdata);
              chk("bus_wsel", 32'(o_bus_wsel), 32'(p.wsel));
            end
            if (n == p.delay) begin
              i_bus_rdata = p.rdata; i_bus_ack = 1'b1;
              @(negedge i_clk);
              i_bus_ack = 1'b0; i_bus_rdata = $urandom;
              break;
            end
            @(negedge i_clk);
            n++;
            if (!o_bus_req) begin
              if (!i_reset) chk("timeout_req_cycles", 32'(n), 32'(TO));
              break;
            end
          end
        end
      end
    end
  end

  initial begin
    instr_t t;
    int m, w;
    repeat (3) @(negedge i_clk);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_req", 32'(o_bus_req), 32'd0);
    chk("rst_flags", {29'd0, o_to_trap, o_misaligned, o_access_fault}, 32'd0);
    chk("rst_reg_write", 32'(o_reg_write), 32'd0);
    chk("rst_result", o_result, 32'd0);
    i_reset = 1'b0;

    t = blank(); t.load = 1; t.f3 = 3'b000; t.add = 32'h1003; t.rdata = 32'h80FF_FF12;
    t.rw = 1; t.rd = 5'd5; issue(t, 0);
    t.f3 = 3'b100; t.rd = 5'd6; issue(t, 0);
    t = blank(); t.store = 1; t.f3 = 3'b010; t.add = 32'h2000; t.wsel = 4'hF;
    t.wdata = 32'hDEAD_BEEF; t.rw = 1; t.delay = 3; t.rd = 5'd9; issue(t, 0);
    t = blank(); t.load = 1; t.f3 = 3'b010; t.add = 32'h1002; t.rw = 1; t.rd = 5'd3; issue(t, 0);
    t = blank(); t.load = 1; t.f3 = 3'b010; t.add = 32'h3000; t.rw = 1; t.delay = 7; t.rd = 5'd4; issue(t, 0);
    t = blank(); t.load = 1; t.f3 = 3'b010; t.add = 32'h4000; t.rw = 1; t.delay = 2; t.rd = 5'd8; issue(t, 2);
    t = blank(); t.result = 32'h1234; t.rw = 1; t.rd = 5'd7; issue(t, 0);
    t = blank(); t.result = 32'h5678; t.rw = 1; t.rd = 5'd10; issue(t, 1);
    t = blank(); t.trap = 1; t.load = 1; t.add = 32'h6000; t.rw = 1; t.rd = 5'd11; issue(t, 0);

    for (int i = 0; i < 300; i++) begin
      t = rand_instr();
      m = ($urandom_range(0, 9) == 0) ? 2 : (($urandom_range(0, 19) == 0) ? 1 : 0);
      issue(t, m);
      repeat ($urandom_range(0, 2)) @(negedge i_clk);
    end

    w = 0;
    while (exp_q.size() != 0 && w < 200) begin @(negedge i_clk); w++; end
    repeat (12) @(negedge i_clk);
    chk("drain_wb_queue", 32'(exp_q.size()), 32'd0);
    chk("drain_bus_queue", 32'(bus_q.size()), 32'd0);

    t = blank(); t.load = 1; t.f3 = 3'b010; t.add = 32'h5000; t.rw = 1; t.delay = 10; t.rd = 5'd12;
    issue(t, 0);
    @(negedge i_clk); @(negedge i_clk);
    #2 i_reset = 1'b1;
    #1;
    chk("midbus_rst_req", 32'(o_bus_req), 32'd0);
    chk("midbus_rst_ready", 32'(o_ready), 32'd1);
    chk("midbus_rst_valid", 32'(o_valid), 32'd0);
    @(negedge i_clk); @(negedge i_clk);
    i_reset = 1'b0;
    exp_q.delete(); bus_q.delete();

    t = blank(); t.result = 32'hCAFE_0001; t.rw = 1; t.rd = 5'd13; issue(t, 0);
    w = 0;
    while (exp_q.size() != 0 && w < 50) begin @(negedge i_clk); w++; end
    chk("final_wb_queue", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_lsu.md
# rv_lsu

Load/store unit sitting directly downstream of the second ALU stage. It takes the computed address, the pre-aligned store data and byte enables, and drives a single-outstanding request/acknowledge data bus. Loaded data is byte-lane extracted and sign/zero-extended before being passed with rd/reg_write to write-back. Misalignment and bus timeout are reported as traps; non-memory instructions pass through in one registered cycle.

## Interface
- BUS_TIMEOUT, 8'd255 — cycles to wait for i_bus_ack before raising an access fault; 0 disables the timeout.
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_flush  in  1  kill instruction in flight (see Operation).
- i_valid  in  1  upstream presents an instruction.
- o_ready  out  1  LSU can accept; upstream holds its outputs while low.
- i_add  in  32  effective address / ALU result.
- i_result  in  32  non-load result to forward.
- i_load, i_store  in  1  memory op kind (mutually exclusive).
- i_wdata  in  32  lane-aligned store data.
- i_wsel  in  4  store byte enables.
- i_funct3  in  3  size/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- i_reg_write  in  1; i_rd  in  5; i_to_trap  in  1.
- o_bus_req  out  1; o_bus_we  out  1; o_bus_addr  out  32 (word-aligned, [1:0]=0); o_bus_wdata  out  32; o_bus_wsel  out  4.
- i_bus_ack  in  1; i_bus_rdata  in  32.
- o_valid  out  1  write-back data valid; o_result  out  32; o_rd  out  5; o_reg_write  out  1.
- o_to_trap  out  1  passthrough trap; o_misaligned  out  1; o_access_fault  out  1.

## Operation
- States (lsu_state_t): IDLE, BUS, RESP.
- IDLE: o_ready=1. On i_valid: capture all inputs. Non-memory op → o_valid next cycle with o_result=i_result. Memory op aligned → BUS. Misaligned (lh/lhu/sh with add[0]=1; lw/sw with add[1:0]≠0) → no bus access, o_valid+o_misaligned next cycle, o_reg_write=0.
- BUS: o_ready=0; o_bus_req=1, address/data/wsel/we stable until i_bus_ack. On ack: loads latch i_bus_rdata → RESP; stores → RESP. Timeout counter increments each BUS cycle; reaching BUS_TIMEOUT (non-zero) drops req, → RESP with o_access_fault=1, o_reg_write=0.
- RESP: o_valid=1 for one cycle with extracted load data; → IDLE. o_ready=0 in RESP.
- Load extraction: byte lane = add[1:0], halfword lane = add[1]; lb/lh sign-extend, lbu/lhu zero-extend, lw unmodified.
- Stores: o_reg_write=0 on completion.
- Flush in IDLE/RESP: o_valid, o_reg_write, trap flags cleared next cycle; state → IDLE. Flush in BUS: request held until ack (bus protocol never retracts req), then → IDLE with o_valid=0; sticky kill flag tracks this.
- Flush and i_valid same cycle: flush wins, nothing captured.
- i_to_trap captured: no bus access, forwarded on o_to_trap with o_valid, o_reg_write=0.

## Timing
- Reset: state=IDLE, all outputs 0 except o_ready=1; counter 0, kill flag 0.
- Non-memory/misaligned latency: 1 cycle capture→o_valid.
- Memory: capture cycle N, req asserted N+1, ack at cycle A (≥N+1), o_valid at A+1. Zero-wait-state ack gives 2-cycle load latency; throughput one memory op per 3 cycles.
- Ack sampled only while req=1; ack in IDLE/RESP ignored.
- Timeout: fault raised when counter==BUS_TIMEOUT, i.e. after BUS_TIMEOUT req cycles without ack; counter is 8 bits, cleared on BUS entry.
- Outputs all registered; o_ready combinational from state.

## Structure
- lsu_state_t and `LSU_IDLE/`LSU_BUS/`LSU_RESP go in the shared defines/structs headers beside the ALU state definitions.
- Sub-module lsu_rdata_ext: combinational lane select + sign/zero extension (funct3, addr[1:0], rdata → 32-bit result), reusable by a future cache.

## Test plan
- Reset mid-BUS: assert i_reset while req=1 → req=0, o_ready=1, o_valid=0 immediately.
- lb at 0x1003, rdata 0x80FF_FF12, ack same cycle as req → o_result 0xFFFF_FF80, o_valid 2 cycles after capture; lbu same → 0x0000_0080.
- sw addr 0x2000, wsel 4'hF, ack after 3 wait cycles → o_bus_we=1 stable for 4 cycles, o_valid with o_reg_write=0.
- lw at 0x1002 → no req, o_misaligned=1, o_reg_write=0 next cycle.
- BUS_TIMEOUT=4, no ack → req for 4 cycles, then o_access_fault=1, back to IDLE.
- Flush during BUS with ack 2 cycles later → req held until ack, no o_valid, next instruction accepted afterwards.
